cache_repl_ctrl: RTL
====================

Name: cache_repl_ctrl

Overview:
Replacement controller for the N-way set-associative L1 cache. It holds one tree pseudo-LRU (PLRU) state vector per set and accepts way-hit updates from the lookup pipeline. It answers victim requests from the miss/refill engine with a registered valid/ready handshake. After reset or on flush it sequences an initialisation sweep over all sets.

Parameters:
NUM_SETS, 64, number of cache sets; power of two, at least 2
NUM_WAYS, 4, associativity; power of two, 2..8
SET_W, $clog2(NUM_SETS), set index width (derived)
WAY_W, $clog2(NUM_WAYS), way index width (derived)

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_i  in  1  reset; synchronous, active-high
flush_i  in  1  single-cycle pulse; clear all PLRU state
busy_o  out  1  high while the init sweep is running
upd_valid_i  in  1  hit touch strobe; no ready, always accepted outside INIT
upd_set_i  in  SET_W  set of the hit
upd_way_i  in  WAY_W  way that hit
vic_req_i  in  1  victim request valid
vic_ready_o  out  1  victim request accepted when vic_req_i and vic_ready_o are both high
vic_set_i  in  SET_W  set needing a fill
vic_valid_mask_i  in  NUM_WAYS  per-way valid bits of that set, bit i = way i
vic_rsp_valid_o  out  1  victim response valid
vic_rsp_ready_i  in  1  consumer accepts response
vic_way_o  out  WAY_W  selected victim way

Behaviour:
- PLRU storage: NUM_SETS x (NUM_WAYS-1) flops in heap order. Node 0 is the root; node k has children 2k+1 and 2k+2.
- Node value 0 sends the victim search into the left (lower-index) subtree; value 1 sends it into the right subtree.
- Touch(way): every node on the path to that way is set to point away from it.
- Victim selection, evaluated on the pre-touch state:
  - If vic_valid_mask_i is not all ones, the victim is the lowest-index invalid way.
  - Otherwise, walk the tree from the root to a leaf.
- FSM states: INIT, IDLE, RESP.
- INIT: sweep counter starts at 0 and clears one set per cycle. Exactly NUM_SETS cycles, then go to IDLE.
  - busy_o=1, vic_ready_o=0, updates ignored.
- IDLE: vic_ready_o=1.
  - On accept: register vic_way_o, touch the victim way in vic_set_i (fill counts as use), go to RESP.
- RESP: vic_rsp_valid_o=1; vic_way_o is held stable; vic_ready_o=0.
  - On vic_rsp_ready_i: go to IDLE (next request can be accepted the following cycle). Throughput is 1 victim per 2 cycles.
- Latency: response is valid the cycle after accept.
- Updates are applied in IDLE and RESP, touching upd_set_i with upd_way_i.
- Same-cycle update and victim accept to the same set:
  - The victim is chosen from the state before either touch.
  - Both touches are applied in order, update first then victim. The victim touch wins at shared nodes.
- Different sets in the same cycle: both touches are applied independently.
- Reset (any state, including mid-sweep or in RESP): state=INIT, sweep counter=0, busy_o=1, vic_ready_o=0, vic_rsp_valid_o=0, vic_way_o=0. All PLRU bits become 0 by the end of the sweep.
- flush_i in IDLE or RESP: drop any pending response (vic_rsp_valid_o=0 next cycle) and enter INIT from set 0.
- flush_i during INIT: restart the sweep at set 0.
- Reset has priority over flush_i; flush_i has priority over vic and upd.
- Out-of-range way indices cannot occur: NUM_WAYS is a power of two.

Test Plan:
- Reset then idle: busy_o high for exactly 64 cycles with vic_ready_o=0. Then busy_o=0, vic_ready_o=1, vic_rsp_valid_o=0.
- NUM_WAYS=4, set 5, full mask 4'b1111, no updates:
  - first victim way 0; state becomes b0=1, b1=1.
  - second victim way 2; third way 1; fourth way 3.
  - Responses are valid 1 cycle after each accept.
- Invalid-first: mask 4'b1011 on set 3 -> victim way 2. Mask 4'b0000 -> way 0. The touch is still applied: a following full-mask request on the same set avoids the touched way.
- Hit ordering: touch set 7 with ways 0, 2, 1, then full-mask request -> victim way 3.
- Same-cycle collision: upd set 9 way 0 together with victim accept on set 9, full mask, from cleared state.
  - Victim is way 0.
  - Next full-mask request on set 9 returns way 2.
- Backpressure and flush:
  - Hold vic_rsp_ready_i=0 for 5 cycles: vic_way_o stays stable and vic_ready_o=0.
  - Pulse flush_i while in RESP: response is dropped, busy_o=1 for 64 cycles.
  - Next request on a previously touched set returns way 0.

Source files
------------

// File: rtl/cache_repl_ctrl.sv
// Tree pseudo-LRU replacement controller: per-set PLRU state, hit touches,
// victim selection over a registered valid/ready handshake, init sweep on reset/flush.
module cache_repl_ctrl #(
   parameter int NUM_SETS = 64,
   parameter int NUM_WAYS = 4,
   parameter int SET_W    = $clog2(NUM_SETS),
   parameter int WAY_W    = $clog2(NUM_WAYS)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                flush_i,
   output logic                busy_o,
   input  logic                upd_valid_i,
   input  logic [SET_W-1:0]    upd_set_i,
   input  logic [WAY_W-1:0]    upd_way_i,
   input  logic                vic_req_i,
   output logic                vic_ready_o,
   input  logic [SET_W-1:0]    vic_set_i,
   input  logic [NUM_WAYS-1:0] vic_valid_mask_i,
   output logic                vic_rsp_valid_o,
   input  logic                vic_rsp_ready_i,
   output logic [WAY_W-1:0]    vic_way_o
);

   localparam int NODES = NUM_WAYS - 1;

   typedef enum logic [1:0] {INIT, IDLE, RESP} state_t;

   state_t           state_q, state_d;
   logic [SET_W-1:0] sweep_q, sweep_d;
   logic [WAY_W-1:0] way_q, way_d;
   logic [NODES-1:0] plru_q [NUM_SETS];
   logic             accept;
   logic             upd_en;

   // Heap-ordered walk: node k has children 2k+1 (left) and 2k+2 (right).
   function automatic logic [NODES-1:0] touch(input logic [NODES-1:0] s,
                                              input logic [WAY_W-1:0] w);
      logic [NODES-1:0] t;
      int unsigned      node;
      logic             dir;
      t    = s;
      node = 0;
      for (int unsigned l = 0; l < WAY_W; l++) begin
         dir     = w[WAY_W-1-l];
         t[node] = ~dir;
         node    = 2 * node + 1 + 32'(dir);
      end
      return t;
   endfunction

   function automatic logic [WAY_W-1:0] pick_victim(input logic [NODES-1:0]    s,
                                                    input logic [NUM_WAYS-1:0] m);
      logic [WAY_W-1:0] w;
      int unsigned      node;
      w    = '0;
      node = 0;
      for (int unsigned l = 0; l < WAY_W; l++) begin
         w[WAY_W-1-l] = s[node];
         node         = 2 * node + 1 + 32'(s[node]);
      end
      // Any invalid way overrides the tree; descending scan leaves the lowest index.
      if (m != '1) begin
         for (int unsigned i = NUM_WAYS; i > 0; i--) begin
            if (!m[i-1]) w = WAY_W'(i - 1);
         end
      end
      return w;
   endfunction

   always_comb begin
      state_d         = state_q;
      sweep_d         = sweep_q;
      way_d           = way_q;
      accept          = 1'b0;
      upd_en          = 1'b0;
      busy_o          = 1'b0;
      vic_ready_o     = 1'b0;
      vic_rsp_valid_o = 1'b0;
      case (state_q)
         INIT: begin
            busy_o  = 1'b1;
            sweep_d = sweep_q + 1'b1;
            if (flush_i) begin
               sweep_d = '0;
            end else if (sweep_q == SET_W'(NUM_SETS - 1)) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            vic_ready_o = 1'b1;
            if (flush_i) begin
               state_d = INIT;
               sweep_d = '0;
            end else begin
               upd_en = upd_valid_i;
               if (vic_req_i) begin
                  accept  = 1'b1;
                  way_d   = pick_victim(plru_q[vic_set_i], vic_valid_mask_i);
                  state_d = RESP;
               end
            end
         end
         RESP: begin
            vic_rsp_valid_o = 1'b1;
            if (flush_i) begin
               state_d = INIT;
               sweep_d = '0;
            end else begin
               upd_en = upd_valid_i;
               if (vic_rsp_ready_i) state_d = IDLE;
            end
         end
         default: begin
            state_d = INIT;
            sweep_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= INIT;
         sweep_q <= '0;
         way_q   <= '0;
      end else begin
         state_q <= state_d;
         sweep_q <= sweep_d;
         way_q   <= way_d;
      end
   end

   // Same-set collision: victim touch is applied on top of the update touch, so it wins.
   always_ff @(posedge clk_i) begin
      if (state_q == INIT) begin
         plru_q[sweep_q] <= '0;
      end else if (!rst_i) begin
         if (upd_en) plru_q[upd_set_i] <= touch(plru_q[upd_set_i], upd_way_i);
         if (accept) plru_q[vic_set_i] <= touch((upd_en && (upd_set_i == vic_set_i))
                                                ? touch(plru_q[vic_set_i], upd_way_i)
                                                : plru_q[vic_set_i], way_d);
      end
   end

   assign vic_way_o = way_q;

endmodule
